// File: rtl/snd_pkg.sv
// Shared constants and bus payload type for the sound channel-1 register front end.
// Length-counter logic in the users of this package is built only when SND_LENGTH_EN is defined.
package snd_pkg;

  localparam logic [15:0] NR10_ADDR = 16'hFF10;
  localparam logic [15:0] NR11_ADDR = 16'hFF11;
  localparam logic [15:0] NR12_ADDR = 16'hFF12;
  localparam logic [15:0] NR13_ADDR = 16'hFF13;
  localparam logic [15:0] NR14_ADDR = 16'hFF14;
  localparam logic [15:0] NR52_ADDR = 16'hFF26;

  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned FREQ_W          = 11;
  localparam int unsigned LEN_W           = 7;
  localparam int unsigned LEN_MAX         = 64;
  localparam int unsigned LEN_DIV_DEFAULT = 31250;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_bus_t;

  // NR11[5:0] holds the remaining length as 64 minus the written value (1..64).
  function automatic logic [LEN_W-1:0] nr11_len(input logic [5:0] d);
    return LEN_W'(LEN_MAX) - LEN_W'(d);
  endfunction

endpackage

// File: rtl/bus_wr_sync.sv
// Synchronises the asynchronous CPU write strobe, holds address/data while it is low,
// and flags a one-cycle commit on the strobe's rising edge.
module bus_wr_sync
  import snd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_8m,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_data,
  input  logic              i_cpu_wr_n,
  output logic              o_commit_c,
  output logic [ADDR_W-1:0] o_c_addr,
  output logic [DATA_W-1:0] o_c_data
);

  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("bus_wr_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  wr_bus_t                r_hold;

  // Sync chain and history idle high so reset never fabricates a rising edge.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_sync <= '1;
      r_hist <= 1'b1;
      r_hold <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_cpu_wr_n};
      r_hist <= r_sync[SYNC_STAGES-1];
      if (!r_sync[0]) begin
        r_hold <= '{addr: i_cpu_addr, data: i_cpu_data};
      end
    end
  end

  assign o_commit_c = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign o_c_addr   = r_hold.addr;
  assign o_c_data   = r_hold.data;

endmodule

// File: rtl/snd_ch1_regs.sv
// NR10-NR14 / NR52 register file for sound channel 1, fed by snooped CPU writes.
// Define SND_LENGTH_EN to build the length counter and its 256 Hz divider.
module snd_ch1_regs
  import snd_pkg::*;
#(
  parameter int unsigned LEN_DIV     = LEN_DIV_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_8m,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wr_n,
  output logic [FREQ_W-1:0] freq,
  output logic              start_sound,
  output logic [3:0]        env_init,
  output logic              env_dir,
  output logic [2:0]        env_period,
  output logic [1:0]        duty,
  output logic [6:0]        sweep,
  output logic              ch1_on,
  output logic              snd_power
);

  if (LEN_DIV < 1) begin : g_div_chk
    $error("snd_ch1_regs: LEN_DIV must be at least 1");
  end

  logic              w_commit;
  logic [ADDR_W-1:0] w_c_addr;
  logic [DATA_W-1:0] w_c_data;

  bus_wr_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_wr_sync (
    .clk_8m     (clk_8m),
    .rst        (rst),
    .i_cpu_addr (cpu_addr),
    .i_cpu_data (cpu_data),
    .i_cpu_wr_n (cpu_wr_n),
    .o_commit_c (w_commit),
    .o_c_addr   (w_c_addr),
    .o_c_data   (w_c_data)
  );

  logic [6:0]        r_sweep,  w_sweep_nx;
  logic [1:0]        r_duty,   w_duty_nx;
  logic [7:0]        r_nr12,   w_nr12_nx;
  logic [FREQ_W-1:0] r_freq,   w_freq_nx;
  logic              r_start,  w_start_nx;
  logic              r_on,     w_on_nx;
  logic              r_power,  w_power_nx;

`ifdef SND_LENGTH_EN
  localparam int unsigned DIV_W = (LEN_DIV > 1) ? $clog2(LEN_DIV) : 1;

  logic [LEN_W-1:0] r_len, w_len_nx;
  logic             r_len_en, w_len_en_nx;
  logic [DIV_W-1:0] r_div, w_div_nx;
  logic             w_tick;

  assign w_tick = (r_div == '0);
`endif

  // Length tick first, then the committed write, so a write always overrides the tick.
  always_comb begin
    w_sweep_nx = r_sweep;
    w_duty_nx  = r_duty;
    w_nr12_nx  = r_nr12;
    w_freq_nx  = r_freq;
    w_start_nx = 1'b0;
    w_on_nx    = r_on;
    w_power_nx = r_power;
`ifdef SND_LENGTH_EN
    w_len_nx    = r_len;
    w_len_en_nx = r_len_en;
    w_div_nx    = w_tick ? DIV_W'(LEN_DIV - 1) : r_div - DIV_W'(1);
    if (w_tick && r_len_en && (r_len != '0)) begin
      w_len_nx = r_len - LEN_W'(1);
      if (r_len == LEN_W'(1)) begin
        w_on_nx = 1'b0;
      end
    end
`endif
    if (w_commit) begin
      case (w_c_addr)
        NR10_ADDR: if (r_power) w_sweep_nx = w_c_data[6:0];
        NR11_ADDR: if (r_power) begin
          w_duty_nx = w_c_data[7:6];
`ifdef SND_LENGTH_EN
          w_len_nx  = nr11_len(w_c_data[5:0]);
`endif
        end
        NR12_ADDR: if (r_power) w_nr12_nx = w_c_data;
        NR13_ADDR: if (r_power) w_freq_nx[7:0] = w_c_data;
        NR14_ADDR: if (r_power) begin
          w_freq_nx[10:8] = w_c_data[2:0];
`ifdef SND_LENGTH_EN
          w_len_en_nx = w_c_data[6];
`endif
          if (w_c_data[7]) begin
            w_on_nx    = 1'b1;
            w_start_nx = 1'b1;
`ifdef SND_LENGTH_EN
            if (w_len_nx == '0) begin
              w_len_nx = LEN_W'(LEN_MAX);
            end
`endif
          end
        end
        NR52_ADDR: begin
          w_power_nx = w_c_data[7];
          if (!w_c_data[7]) begin
            w_sweep_nx = '0;
            w_duty_nx  = '0;
            w_nr12_nx  = '0;
            w_freq_nx  = '0;
            w_on_nx    = 1'b0;
`ifdef SND_LENGTH_EN
            w_len_nx    = '0;
            w_len_en_nx = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_sweep  <= '0;
      r_duty   <= '0;
      r_nr12   <= '0;
      r_freq   <= '0;
      r_start  <= 1'b0;
      r_on     <= 1'b0;
      r_power  <= 1'b0;
`ifdef SND_LENGTH_EN
      r_len    <= '0;
      r_len_en <= 1'b0;
      r_div    <= '0;
`endif
    end else begin
      r_sweep  <= w_sweep_nx;
      r_duty   <= w_duty_nx;
      r_nr12   <= w_nr12_nx;
      r_freq   <= w_freq_nx;
      r_start  <= w_start_nx;
      r_on     <= w_on_nx;
      r_power  <= w_power_nx;
`ifdef SND_LENGTH_EN
      r_len    <= w_len_nx;
      r_len_en <= w_len_en_nx;
      r_div    <= w_div_nx;
`endif
    end
  end

  assign freq        = r_freq;
  assign start_sound = r_start;
  assign env_init    = r_nr12[7:4];
  assign env_dir     = r_nr12[3];
  assign env_period  = r_nr12[2:0];
  assign duty        = r_duty;
  assign sweep       = r_sweep;
  assign ch1_on      = r_on;
  assign snd_power   = r_power;

endmodule
